// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned add/sub/shift-add multiply/restoring divide
// Ports: clk, rst (sync, active high), start, op (01 add, 10 sub, 11 mul, 00 div),
//   data_in_a, data_in_b (WIDTH operands); busy, done (1-cycle pulse),
//   data_out (2*WIDTH registered result, {rem,quo} for divide), div_zero.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     data_in_a,
  input  logic [WIDTH-1:0]     data_in_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   data_out,
  output logic                 div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [1:0] op_r;
  logic dz_r;
  logic [2*WIDTH-1:0] acc, x;
  logic [WIDTH-1:0] y;
  logic [CW-1:0] cnt;
  logic accept, last, fast, b_zero;
  logic [WIDTH:0] trial, diff;
  assign b_zero = ~|data_in_b;
  assign accept = state == IDLE && start;
  assign last = cnt == CW'(WIDTH - 1);
  // add/sub and divide-by-zero complete without iterating
  assign fast = (op[0] ^ op[1]) | (~|op & b_zero);
  // restoring divide step: acc[W-1:0] is the partial remainder, y shifts the
  // dividend out at the top and collects quotient bits at the bottom; since the
  // remainder stays below the divisor, diff's top bit is the borrow
  assign trial = {acc[WIDTH-1:0], y[WIDTH-1]};
  assign diff = trial - {1'b0, x[WIDTH-1:0]};
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (start ? (fast ? DONE : CALC) : IDLE) :
          state == CALC ? (last ? DONE : CALC) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      data_out <= '0;
      div_zero <= 1'b0;
      op_r <= '0;
      dz_r <= 1'b0;
      acc <= '0;
      x <= '0;
      y <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_r <= op;
        dz_r <= ~|op & b_zero;
        cnt <= '0;
        busy <= 1'b1;
        acc <= op == 2'b01 ? {{WIDTH{1'b0}}, data_in_a} + {{WIDTH{1'b0}}, data_in_b} :
               op == 2'b10 ? {{WIDTH{1'b0}}, data_in_a} - {{WIDTH{1'b0}}, data_in_b} :
               op == 2'b00 && b_zero ? {data_in_a, {WIDTH{1'b1}}} : '0;
        x <= {{WIDTH{1'b0}}, op == 2'b11 ? data_in_a : data_in_b};
        y <= op == 2'b11 ? data_in_b : data_in_a;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (op_r == 2'b11) begin
          acc <= acc + (y[0] ? x : '0);
          x <= x << 1;
          y <= y >> 1;
        end else begin
          acc <= {{WIDTH{1'b0}}, diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0]};
          y <= {y[WIDTH-2:0], ~diff[WIDTH]};
        end
      end else if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
        div_zero <= dz_r;
        data_out <= (op_r == 2'b00 && !dz_r) ? {acc[WIDTH-1:0], y} : acc;
      end
    end
  end
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed scoreboard bench for seq_arith_unit (WIDTH=8)
module tb_seq_arith_unit;
  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] op;
  logic [7:0] data_in_a, data_in_b;
  logic busy, done, div_zero;
  logic [15:0] data_out;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [15:0] d;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];
  seq_arith_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .busy(busy), .done(done), .data_out(data_out), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ed, input logic edz, input int lat, input bit scr);
    bit seen = 0;
    int nb = 0;
    @(negedge clk);
    rst = 1'b0;
    op = o;
    data_in_a = a;
    data_in_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{ed, edz, cyc, lat});
    chk("busy_after_accept", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        start = 1'b0;
        seen = 1;
        break;
      end
      if (busy) nb++;
      if (scr) begin
        start = ~start;
        op = 2'($urandom);
        data_in_a = 8'($urandom);
        data_in_b = 8'($urandom);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(nb), 32'(lat - 1));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("data_out_held", 32'(data_out), 32'(ed));
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    data_in_a = '0;
    data_in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    run_op(2'b01, 8'd200, 8'd100, 16'h012C, 1'b0, 1, 0);
    run_op(2'b10, 8'd5,   8'd10,  16'hFFFB, 1'b0, 1, 0);
    run_op(2'b10, 8'd10,  8'd5,   16'h0005, 1'b0, 1, 0);
    run_op(2'b11, 8'd255, 8'd255, 16'hFE01, 1'b0, 9, 1);
    run_op(2'b00, 8'd200, 8'd7,   16'h041C, 1'b0, 9, 1);
    run_op(2'b00, 8'd200, 8'd0,   16'hC8FF, 1'b1, 1, 0);
    run_op(2'b01, 8'd1,   8'd2,   16'h0003, 1'b0, 1, 0);
    run_op(2'b11, 8'd13,  8'd11,  16'h008F, 1'b0, 9, 0);
    run_op(2'b00, 8'd7,   8'd200, 16'h0700, 1'b0, 9, 0);
    run_op(2'b00, 8'd255, 8'd1,   16'h00FF, 1'b0, 9, 0);
    // back-to-back: start held high is accepted again two edges later
    @(negedge clk);
    op = 2'b01;
    data_in_a = 8'd3;
    data_in_b = 8'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{16'h0007, 1'b0, cyc, 1});
    q.push_back('{16'h0007, 1'b0, cyc + 2, 1});
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_drained", 32'(q.size()), 32'd0);
    // reset three cycles into a multiply aborts it silently
    @(negedge clk);
    op = 2'b11;
    data_in_a = 8'd255;
    data_in_b = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_data", 32'(data_out), 32'd0);
    chk("abort_dz", 32'(div_zero), 32'd0);
    run_op(2'b01, 8'd20, 8'd30, 16'h0032, 1'b0, 1, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled on each rising edge.
REQ-005 SHALL have port op  input  2  operation: 2'b01 add, 2'b10 subtract, 2'b11 multiply, 2'b00 divide.
REQ-006 SHALL have port data_in_a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port data_in_b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-009 SHALL have port done  output  1  one-cycle pulse; data_out and div_zero valid.
REQ-010 SHALL have port data_out  output  2*WIDTH  registered result, held between operations.
REQ-011 SHALL have port div_zero  output  1  last divide had data_in_b == 0; valid with done, held afterwards.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, start==1 at edge k SHALL latch op, data_in_a and data_in_b and SHALL set busy=1 at edge k.
REQ-014 Operand or op changes after edge k SHALL NOT affect the accepted operation.
REQ-015 Add SHALL produce zero-extended a+b (no overflow possible in 2*WIDTH bits); IDLE->DONE at edge k.
REQ-016 Subtract SHALL produce (a-b) mod 2^(2*WIDTH), operands zero-extended first; IDLE->DONE at edge k.
REQ-017 Multiply SHALL be iterative shift-and-add, one multiplier bit per cycle; IDLE->CALC at edge k.
REQ-018 Multiply SHALL yield the exact 2*WIDTH-bit unsigned product.
REQ-019 Divide SHALL be restoring, one quotient bit per cycle; IDLE->CALC at edge k.
REQ-020 Divide SHALL yield data_out = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
REQ-021 CALC SHALL last exactly WIDTH cycles, tracked by an iteration counter; CALC->DONE at edge k+WIDTH.
REQ-022 Divide with data_in_b==0 SHALL skip CALC (IDLE->DONE at edge k).
REQ-023 Divide-by-zero SHALL give quotient all ones, remainder = data_in_a and div_zero=1.
REQ-024 Every other completed operation SHALL clear div_zero.
REQ-025 On entry to DONE, data_out/div_zero SHALL update, done=1 and busy=0 for exactly one cycle; DONE->IDLE on the next edge.
REQ-026 Latency from accepting edge to done high SHALL be 1 cycle for add, subtract and divide-by-zero, and WIDTH+1 cycles for multiply and divide.
REQ-027 start while busy==1 or in DONE SHALL be ignored, with no queuing.
REQ-028 Back-to-back: start held high SHALL be accepted again on the first edge back in IDLE.
REQ-029 data_out SHALL NOT change except on entry to DONE or on reset.

Reset
REQ-030 rst==1 at an edge SHALL force IDLE, busy=0, done=0, data_out=0, div_zero=0 and clear internal registers.
REQ-031 rst SHALL take priority over start and abort any operation mid-CALC with no done pulse.
REQ-032 The first start SHALL be accepted on the first edge with rst==0.

Verification (WIDTH=8)
REQ-033 SHALL cover add: a=200, b=100 -> data_out=16'h012C, done 1 cycle after accept, div_zero=0.
REQ-034 SHALL cover subtract: a=5, b=10 -> data_out=16'hFFFB; and a=10, b=5 -> 16'h0005.
REQ-035 SHALL cover multiply: a=255, b=255 -> data_out=16'hFE01, done exactly 9 cycles after accept, busy high 8 cycles.
REQ-036 SHALL cover divide: a=200, b=7 -> data_out=16'h041C (rem 4, quo 28) after 9 cycles.
REQ-037 SHALL cover divide-by-zero: a=200, b=0 -> data_out=16'hC8FF, div_zero=1, done after 1 cycle.
REQ-038 SHALL cover rst asserted 3 cycles into a multiply -> no done, outputs zero next cycle; a new add is accepted afterwards and completes correctly.
REQ-039 SHALL cover start pulses and operand changes during CALC -> ignored; the original result is unchanged.
